store_align_queue: RTL
======================

// Module: store_align_queue
// PURPOSE
//  Store-side counterpart of the load data masker. Takes SB/SH/SW requests from the
//  MEM stage and converts each to a word address, replicated write data and a 4-bit
//  byte-enable (big-endian: byte offset 0 = bits 31:24). Holds them in a small
//  in-order queue that drains to the data memory port with a valid/ready handshake.
//  Flags loads that hit a pending store, and drops and flags misaligned stores.
// PARAMETERS
//  DEPTH   4  queue entries; power of two, >= 2
//  PTR_W   2  log2(DEPTH)
// PORTS
//  clk         in   1   system clock; all state updates on the rising edge
//  rst         in   1   synchronous reset, active-high
//  st_valid    in   1   store request valid
//  st_ready    out  1   queue can accept a request
//  st_opcode   in   6   opcode (`SB/`SH/`SW from Opcode.vh)
//  st_addr     in   32  byte address
//  st_data     in   32  rt register value
//  mem_valid   out  1   head entry valid toward memory
//  mem_ready   in   1   memory accepts the head entry
//  mem_addr    out  30  word address (st_addr[31:2])
//  mem_data    out  32  aligned write data
//  mem_we      out  4   byte enables; bit 3 = bits 31:24
//  ld_addr     in   32  address of the load in the MEM stage
//  ld_valid    in   1   a load is present
//  ld_hazard   out  1   the load word matches a resident queue entry
//  misaligned  out  1   one-cycle pulse: a misaligned store was dropped
//  empty       out  1   queue holds no entries
// BEHAVIOUR
//  Reset: head/tail ptr=0, count=0, all entries zeroed; mem_valid=0, mem_addr=0,
//   mem_data=0, mem_we=0, misaligned=0, ld_hazard=0, empty=1, st_ready=1.
//  Accept: st_valid && st_ready. st_ready = (count != DEPTH). When full, st_ready stays
//   0 even if a dequeue happens the same cycle (no bypass).
//  Alignment, with off = st_addr[1:0]:
//   SB: data={4{d[7:0]}}, we=4'b1000>>off.
//   SH: requires off[0]=0. data={2{d[15:0]}}, we = off[1] ? 4'b0011 : 4'b1100.
//   SW: requires off=0. data=d, we=4'b1111.
//  A misaligned SH/SW is accepted but not enqueued; misaligned=1 on the following cycle.
//  A non-store opcode is accepted and ignored, with no flag.
//  Latency: an entry enqueued at edge N is on mem_* from cycle N+1. mem_* are driven
//   from the head entry register. mem_valid = !empty.
//  Dequeue on mem_valid && mem_ready. mem_* stay stable while mem_valid && !mem_ready.
//  Simultaneous enqueue and dequeue (not full): count is unchanged and both pointers
//   advance. Pointers wrap modulo DEPTH.
//  Empty queue with mem_ready=1: no dequeue, count stays 0.
//  ld_hazard = ld_valid && (some resident entry has addr == ld_addr[31:2]), compared
//   combinationally. The store being accepted in the same cycle is not compared.
//   Forced to 0 when empty.
//  Reset mid-drain: every entry is discarded and mem_valid drops on the next cycle.
// STRUCTURE
//  Opcode.vh supplies `SB/`SH/`SW. New shared header StoreMask.vh holds the we
//   constants (WE_B0..WE_B3, WE_HI, WE_LO, WE_W).
//  One sub-module, store_align (combinational): opcode+off+data -> data, we, misalign.
//  Queue storage, pointers and the hazard compare live in store_align_queue.
// TESTING
//  1 SB addr=0x103, data=0xAB -> mem_addr=0x40, data=0xABABABAB, we=0001 next cycle.
//  2 SH addr=0x202 d=0x1234 -> we=0011, data=0x12341234; SH addr=0x201 -> misaligned
//    pulses 1 cycle, nothing enqueued.
//  3 mem_ready=0, push 4 SW -> st_ready=0 after the 4th; then mem_ready=1 -> drains in
//    order, one entry per cycle, and empty=1 after the 4th.
//  4 Full queue with a push and a pop in the same cycle -> push refused; next cycle
//    st_ready=1, count=3.
//  5 SW to 0x80 pending, ld_addr=0x83, ld_valid=1 -> ld_hazard=1. After the drain
//    -> ld_hazard=0.
//  6 rst asserted with 3 entries queued -> next cycle mem_valid=0, empty=1,
//    mem_we=0.

Source files
------------

// File: rtl/store_align_queue_pkg.sv
// Shared constants and types for the store alignment queue: opcodes, byte-enable
// patterns (big-endian, bit 3 = bits 31:24) and the queue entry layout.
package store_align_queue_pkg;

   localparam int DEPTH = 4;
   localparam int PTR_W = 2;
   localparam int CNT_W = PTR_W + 1;

   localparam logic [5:0] OP_SB = 6'h28;
   localparam logic [5:0] OP_SH = 6'h29;
   localparam logic [5:0] OP_SW = 6'h2b;

   localparam logic [3:0] WE_B0   = 4'b1000;
   localparam logic [3:0] WE_B1   = 4'b0100;
   localparam logic [3:0] WE_B2   = 4'b0010;
   localparam logic [3:0] WE_B3   = 4'b0001;
   localparam logic [3:0] WE_HI   = 4'b1100;
   localparam logic [3:0] WE_LO   = 4'b0011;
   localparam logic [3:0] WE_W    = 4'b1111;
   localparam logic [3:0] WE_NONE = 4'b0000;

   typedef struct packed {
      logic [29:0] addr;
      logic [31:0] data;
      logic [3:0]  we;
   } sq_entry_t;

endpackage

// File: rtl/store_align_queue_if.sv
// Bundle of the store request, memory drain and load hazard signals of the queue.
interface store_align_queue_if;

   logic        st_valid;
   logic        st_ready;
   logic [5:0]  st_opcode;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [29:0] mem_addr;
   logic [31:0] mem_data;
   logic [3:0]  mem_we;
   logic [31:0] ld_addr;
   logic        ld_valid;
   logic        ld_hazard;
   logic        misaligned;
   logic        empty;

   modport master (
      output st_valid, st_opcode, st_addr, st_data, mem_ready, ld_addr, ld_valid,
      input  st_ready, mem_valid, mem_addr, mem_data, mem_we, ld_hazard, misaligned, empty
   );

   modport slave (
      input  st_valid, st_opcode, st_addr, st_data, mem_ready, ld_addr, ld_valid,
      output st_ready, mem_valid, mem_addr, mem_data, mem_we, ld_hazard, misaligned, empty
   );

endinterface

// File: rtl/store_align_queue_align.sv
// Combinational store formatter: replicates write data across the word and builds
// the big-endian byte enables, flagging SH/SW requests that are not naturally aligned.
module store_align
   import store_align_queue_pkg::*;
(
   input  logic [5:0]  opcode,
   input  logic [1:0]  off,
   input  logic [31:0] data,
   output logic [31:0] al_data,
   output logic [3:0]  al_we,
   output logic        is_store,
   output logic        misalign
);

   // Decode opcode and byte offset into aligned data and byte enables.
   always_comb begin
      al_data  = 32'h0000_0000;
      al_we    = WE_NONE;
      is_store = 1'b0;
      misalign = 1'b0;
      case (opcode)
         OP_SB: begin
            is_store = 1'b1;
            al_data  = {4{data[7:0]}};
            case (off)
               2'd0:    al_we = WE_B0;
               2'd1:    al_we = WE_B1;
               2'd2:    al_we = WE_B2;
               2'd3:    al_we = WE_B3;
               default: al_we = WE_NONE;
            endcase
         end
         OP_SH: begin
            is_store = 1'b1;
            al_data  = {2{data[15:0]}};
            if (off[0]) begin
               misalign = 1'b1;
            end else begin
               al_we = off[1] ? WE_LO : WE_HI;
            end
         end
         OP_SW: begin
            is_store = 1'b1;
            al_data  = data;
            if (off != 2'b00) begin
               misalign = 1'b1;
            end else begin
               al_we = WE_W;
            end
         end
         default: begin
            is_store = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/store_align_queue.sv
// In-order store queue: formats SB/SH/SW requests, drains them to data memory over
// a valid/ready handshake and flags loads whose word matches a pending store.
module store_align_queue
   import store_align_queue_pkg::*;
(
   input logic               clk,
   input logic               rst,
   store_align_queue_if.slave bus
);

   sq_entry_t        entries [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic             misaligned_r;

   logic [31:0]      al_data;
   logic [3:0]       al_we;
   logic             is_store;
   logic             misalign;
   logic             accept;
   logic             do_enq;
   logic             do_deq;
   logic             empty;
   logic             hit;
   logic [PTR_W-1:0] slot;
   logic             unused_bits;

   store_align u_align (
      .opcode   (bus.st_opcode),
      .off      (bus.st_addr[1:0]),
      .data     (bus.st_data),
      .al_data  (al_data),
      .al_we    (al_we),
      .is_store (is_store),
      .misalign (misalign)
   );

   assign unused_bits = ^bus.ld_addr[1:0];

   // Handshake qualification; a full queue refuses even if it drains this cycle.
   always_comb begin
      empty  = (count == CNT_W'(0));
      accept = bus.st_valid && (count != CNT_W'(DEPTH));
      do_enq = accept && is_store && !misalign;
      do_deq = !empty && bus.mem_ready;
   end

   // Queue storage, pointers, occupancy and the misaligned-drop pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         misaligned_r <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else begin
         if (do_enq) begin
            entries[tail] <= '{addr: bus.st_addr[31:2], data: al_data, we: al_we};
            tail          <= tail + PTR_W'(1);
         end
         if (do_deq) begin
            head <= head + PTR_W'(1);
         end
         if (do_enq && !do_deq) begin
            count <= count + CNT_W'(1);
         end else if (!do_enq && do_deq) begin
            count <= count - CNT_W'(1);
         end else begin
            count <= count;
         end
         misaligned_r <= accept && is_store && misalign;
      end
   end

   // Only slots between head and head+count hold live stores; stale slots are ignored.
   always_comb begin
      hit  = 1'b0;
      slot = head;
      for (int i = 0; i < DEPTH; i++) begin
         slot = head + PTR_W'(i);
         if ((CNT_W'(i) < count) && (entries[slot].addr == bus.ld_addr[31:2])) begin
            hit = 1'b1;
         end else begin
            hit = hit;
         end
      end
   end

   // Output drive: memory side straight from the head entry register.
   always_comb begin
      bus.st_ready   = (count != CNT_W'(DEPTH));
      bus.mem_valid  = !empty;
      bus.mem_addr   = entries[head].addr;
      bus.mem_data   = entries[head].data;
      bus.mem_we     = entries[head].we;
      bus.ld_hazard  = bus.ld_valid && !empty && hit;
      bus.misaligned = misaligned_r;
      bus.empty      = empty;
   end

endmodule
